// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM controller: opcodes, frame
// lengths, FSM states and the CPU-access frame builder.
package spi_sram_pkg;

  localparam logic [7:0] SPI_READ  = 8'h03;
  localparam logic [7:0] SPI_WRITE = 8'h02;
  localparam logic [7:0] SPI_WRMR  = 8'h01;
  localparam logic [7:0] MODE_SEQ  = 8'h40;

  // Frame lengths in bits: CPU access (cmd+addr+2 data bytes) and mode write.
  localparam logic [5:0] FRAME_LEN = 6'd40;
  localparam logic [5:0] MODE_LEN  = 6'd16;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_DONE = 3'd1,
    ST_IDLE      = 3'd2,
    ST_XFER      = 3'd3,
    ST_DONE      = 3'd4,
    ST_RELEASE   = 3'd5
  } state_e;

  // Little-endian word: low byte goes to address A, high byte to A+1.
  function automatic logic [39:0] build_frame(input logic        is_write,
                                              input logic [15:0] addr,
                                              input logic [15:0] wdata);
    logic [39:0] f;
    if (is_write) begin
      f = {SPI_WRITE, addr, wdata[7:0], wdata[15:8]};
    end else begin
      f = {SPI_READ, addr, 16'h0000};
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_sram_shifter.sv
// SPI mode-0 bit engine: SCK divider, MSB-first frame shifter and MISO
// capture. A start pulse loads a left-aligned frame of nbits bits; done is
// high in the last cycle of the final SCK high phase.
module spi_sram_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [39:0] frame,
  input  logic [5:0]  nbits,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        active,
  output logic        done,
  output logic [15:0] rx_word
);
  import spi_sram_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          active_q, active_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [15:0]   rx_q, rx_d;
  logic          phase_end_s;
  logic          done_s;

  assign phase_end_s = (div_q == DW'(CLK_DIV - 1));

  // Next-state: divide clk into SCK phases, shift MOSI on the falling edge, sample MISO on the rising edge.
  always_comb begin
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    active_d  = active_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    done_s    = 1'b0;
    if (start) begin
      active_d  = 1'b1;
      sck_d     = 1'b0;
      div_d     = '0;
      bit_cnt_d = nbits - 6'd1;
      mosi_d    = frame[39];
      shreg_d   = {frame[38:0], 1'b0};
    end else if (active_q) begin
      if (phase_end_s) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[14:0], miso};
        end else begin
          sck_d = 1'b0;
          if (bit_cnt_q == 6'd0) begin
            active_d = 1'b0;
            done_s   = 1'b1;
            mosi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 6'd1;
            mosi_d    = shreg_q[39];
            shreg_d   = {shreg_q[38:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers; SCK and MOSI come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      active_q  <= 1'b0;
      div_q     <= '0;
      bit_cnt_q <= 6'd0;
      shreg_q   <= 40'h0;
      rx_q      <= 16'h0000;
    end else begin
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      active_q  <= active_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign active  = active_q;
  assign done    = done_s;
  assign rx_word = rx_q;

endmodule

// File: rtl/spi_sram_ctrl.sv
// CPU memory handshake to 23LC512-class SPI SRAM bridge. Each request moves
// one little-endian 16-bit word in sequential mode.
// Optional: define SPI_SRAM_MODE_INIT_EN to send a WRMR (sequential mode)
// frame after reset before the first request is accepted.
module spi_sram_ctrl #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  import spi_sram_pkg::*;

`ifdef SPI_SRAM_MODE_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e      state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [15:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;

  logic        start_s;
  logic [39:0] frame_s;
  logic [5:0]  nbits_s;
  logic        active_s;
  logic        done_s;
  logic [15:0] rx_word_s;

  // mem_read duplicates !mem_write on this bus and carries no extra information.
  logic        unused_s;
  assign unused_s = mem_read;

  spi_sram_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .frame   (frame_s),
    .nbits   (nbits_s),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .active  (active_s),
    .done    (done_s),
    .rx_word (rx_word_s)
  );

  // FSM next-state and registered-output values for the CPU handshake and chip select.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    start_s    = 1'b0;
    frame_s    = 40'h0;
    nbits_s    = FRAME_LEN;
    case (state_q)
`ifdef SPI_SRAM_MODE_INIT_EN
      ST_INIT: begin
        if (!active_s) begin
          start_s = 1'b1;
          frame_s = {SPI_WRMR, MODE_SEQ, 24'h000000};
          nbits_s = MODE_LEN;
          cs_n_d  = 1'b0;
        end else if (done_s) begin
          cs_n_d  = 1'b1;
          state_d = ST_INIT_DONE;
        end else begin
          cs_n_d  = 1'b0;
        end
      end
      ST_INIT_DONE: begin
        state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (mem_req) begin
          start_s    = 1'b1;
          frame_s    = build_frame(mem_write, mem_addr, mem_wdata);
          nbits_s    = FRAME_LEN;
          is_write_d = mem_write;
          cs_n_d     = 1'b0;
          state_d    = ST_XFER;
        end else begin
          cs_n_d     = 1'b1;
        end
      end
      ST_XFER: begin
        if (done_s) begin
          cs_n_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
          // First received byte came from address A, i.e. the low byte.
          if (!is_write_q) begin
            rdata_d = {rx_word_s[7:0], rx_word_s[15:8]};
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cs_n_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!mem_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops CS immediately, abandoning any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      cs_n_q     <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= 16'h0000;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Self-checking bench for spi_sram_ctrl: two instances (CLK_DIV=1 and 3),
// a behavioural 23LC512 model on the SPI pins and a word-level reference
// memory for expected read data.
module tb_spi_sram_ctrl;

  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_req   [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_ready [2];
  logic        busy      [2];
  logic        spi_cs_n  [2];
  logic        spi_sck   [2];
  logic        spi_mosi  [2];
  logic        spi_miso  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Device model state (written only by the SPI model process)
  logic [7:0]  sram     [2][65536];
  logic        model_init = 1'b0;
  logic        prev_cs  [2];
  logic        prev_sck [2];
  int          bits_m   [2];
  logic [7:0]  sh_m     [2];
  logic [7:0]  cmd_m    [2];
  logic [15:0] ptr_m    [2];
  logic [7:0]  fr_bytes [2][8];
  int          fr_n     [2];
  int          last_bits[2];
  int          cs_falls [2];
  int          wrmr_cnt [2];
  logic [7:0]  mode_m   [2];
  logic        run_valid[2];
  logic        run_lvl  [2];
  int          run_len  [2];
  int          phase_err[2];

  // Reference model (written only by the stimulus process)
  logic [7:0]  ref_mem  [2][65536];
  logic [15:0] exp_rdata[2];

  spi_sram_ctrl #(.CLK_DIV(DIV0)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]), .busy(busy[0]),
    .spi_cs_n(spi_cs_n[0]), .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]),
    .spi_miso(spi_miso[0])
  );

  spi_sram_ctrl #(.CLK_DIV(DIV1)) u_dut_div3 (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]), .busy(busy[1]),
    .spi_cs_n(spi_cs_n[1]), .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]),
    .spi_miso(spi_miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  function automatic logic [7:0] init_byte(input int g, input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ ((g == 0) ? 8'hC3 : 8'h5A);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural serial SRAM, sampled mid-cycle: SCK edges are seen as level changes.
  always @(negedge clk) begin
    int k;
    int idx;
    logic [15:0] a;
    logic [7:0]  b;
    if (!model_init) begin
      for (int i = 0; i < 65536; i++) begin
        sram[0][i] = init_byte(0, 16'(i));
        sram[1][i] = init_byte(1, 16'(i));
      end
      for (int g = 0; g < 2; g++) begin
        prev_cs[g] = 1'b1; prev_sck[g] = 1'b0; bits_m[g] = 0; sh_m[g] = 8'h00;
        cmd_m[g] = 8'h00; ptr_m[g] = 16'h0000; fr_n[g] = 0; last_bits[g] = 0;
        cs_falls[g] = 0; wrmr_cnt[g] = 0; mode_m[g] = 8'h00; run_valid[g] = 1'b0;
        run_lvl[g] = 1'b0; run_len[g] = 0; phase_err[g] = 0; spi_miso[g] = 1'b0;
      end
      model_init = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      if (spi_cs_n[g] === 1'b0) begin
        if (prev_cs[g]) begin
          bits_m[g] = 0; fr_n[g] = 0; cmd_m[g] = 8'h00; cs_falls[g]++;
          run_valid[g] = 1'b0;
        end
        if (spi_sck[g] && !prev_sck[g]) begin
          sh_m[g] = {sh_m[g][6:0], spi_mosi[g]};
          bits_m[g]++;
          if (bits_m[g] % 8 == 0) begin
            k = bits_m[g] / 8 - 1;
            if (fr_n[g] < 8) begin
              fr_bytes[g][fr_n[g]] = sh_m[g];
              fr_n[g]++;
            end
            if (k == 0) cmd_m[g] = sh_m[g];
            else if (k == 1 && cmd_m[g] == 8'h01) begin
              mode_m[g] = sh_m[g];
              wrmr_cnt[g]++;
            end
            else if (k == 1) ptr_m[g][15:8] = sh_m[g];
            else if (k == 2) ptr_m[g][7:0] = sh_m[g];
            else if (cmd_m[g] == 8'h02) begin
              sram[g][ptr_m[g]] = sh_m[g];
              ptr_m[g] = ptr_m[g] + 16'd1;
            end
          end
        end else if (!spi_sck[g] && prev_sck[g]) begin
          if (cmd_m[g] == 8'h03 && bits_m[g] >= 24) begin
            idx = bits_m[g] - 24;
            a = ptr_m[g] + 16'(idx / 8);
            b = sram[g][a];
            spi_miso[g] = b[7 - (idx % 8)];
          end
        end
        if (run_valid[g] && spi_sck[g] == run_lvl[g]) begin
          run_len[g]++;
        end else begin
          if (run_valid[g] && run_len[g] != div_of(g)) phase_err[g]++;
          run_valid[g] = 1'b1;
          run_lvl[g] = spi_sck[g];
          run_len[g] = 1;
        end
      end else begin
        if (!prev_cs[g]) begin
          last_bits[g] = bits_m[g];
          if (run_valid[g] && run_len[g] != div_of(g)) phase_err[g]++;
          run_valid[g] = 1'b0;
        end
        spi_miso[g] = 1'b0;
      end
      prev_cs[g]  = (spi_cs_n[g] !== 1'b0);
      prev_sck[g] = (spi_sck[g] === 1'b1);
    end
  end

  // One CPU access on instance g; call on a negedge. Checks timing, frame, data.
  task automatic do_access(input int g, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int hold);
    int t;
    int rdy;
    int d;
    logic [15:0] a1;
    d  = div_of(g);
    a1 = addr + 16'd1;
    t = 0;
    while (busy[g] !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check_eq("idle_wait", 32'(busy[g]), 32'd0);
    mem_write[g] = wr;
    mem_read[g]  = !wr;
    mem_addr[g]  = addr;
    mem_wdata[g] = wdata;
    mem_req[g]   = 1'b1;
    rdy = 0;
    for (int n = 1; n <= 80 * d + 20; n++) begin
      @(negedge clk);
      if (n == 1) check_eq("cs_fall", 32'(spi_cs_n[g]), 32'd0);
      if (n == 2) begin
        mem_addr[g]  = ~addr;
        mem_wdata[g] = ~wdata;
        mem_write[g] = !wr;
        mem_read[g]  = wr;
      end
      if (mem_ready[g] === 1'b1) begin
        rdy = n;
        break;
      end
    end
    if (rdy == 0) begin
      check_eq("ready_timeout", 32'(mem_ready[g]), 32'd1);
    end else begin
      check_eq("ready_cycle", 32'(rdy), 32'(80 * d + 1));
      if (!wr) exp_rdata[g] = {ref_mem[g][a1], ref_mem[g][addr]};
      check_eq("rdata", 32'(mem_rdata[g]), 32'(exp_rdata[g]));
    end
    if (wr) begin
      ref_mem[g][addr] = wdata[7:0];
      ref_mem[g][a1]   = wdata[15:8];
    end
    for (int h = 0; h < ((hold > 0) ? hold : 1); h++) begin
      @(negedge clk);
      check_eq("ready_pulse", 32'(mem_ready[g]), 32'd0);
    end
    mem_req[g] = 1'b0;
    t = 0;
    while (busy[g] !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check_eq("busy_clear", 32'(busy[g]), 32'd0);
    check_eq("sck_rises", 32'(last_bits[g]), 32'd40);
    check_eq("frame_cmd", 32'(fr_bytes[g][0]), wr ? 32'h02 : 32'h03);
    check_eq("frame_ahi", 32'(fr_bytes[g][1]), 32'(addr[15:8]));
    check_eq("frame_alo", 32'(fr_bytes[g][2]), 32'(addr[7:0]));
    if (wr) begin
      check_eq("frame_b0", 32'(fr_bytes[g][3]), 32'(wdata[7:0]));
      check_eq("frame_b1", 32'(fr_bytes[g][4]), 32'(wdata[15:8]));
      check_eq("sram_lo", 32'(sram[g][addr]), 32'(wdata[7:0]));
      check_eq("sram_hi", 32'(sram[g][a1]), 32'(wdata[15:8]));
    end
  endtask

  initial begin
    int falls0;
    logic wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      mem_req[g] = 1'b0; mem_read[g] = 1'b0; mem_write[g] = 1'b0;
      mem_addr[g] = 16'h0000; mem_wdata[g] = 16'h0000; exp_rdata[g] = 16'h0000;
      for (int i = 0; i < 65536; i++) ref_mem[g][i] = init_byte(g, 16'(i));
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq("rst_cs_n", 32'(spi_cs_n[g]), 32'd1);
      check_eq("rst_sck", 32'(spi_sck[g]), 32'd0);
      check_eq("rst_mosi", 32'(spi_mosi[g]), 32'd0);
      check_eq("rst_ready", 32'(mem_ready[g]), 32'd0);
      check_eq("rst_busy", 32'(busy[g]), 32'd0);
      check_eq("rst_rdata", 32'(mem_rdata[g]), 32'd0);
    end

`ifdef SPI_SRAM_MODE_INIT_EN
    // Request raised during INIT: WRMR goes out first, then the access.
    rst_n = 1'b1;
    mem_write[0] = 1'b1; mem_read[0] = 1'b0;
    mem_addr[0] = 16'h0010; mem_wdata[0] = 16'hA55A; mem_req[0] = 1'b1;
    begin
      int rdy;
      rdy = 0;
      for (int n = 1; n <= 300; n++) begin
        @(negedge clk);
        if (mem_ready[0] === 1'b1) begin
          rdy = n;
          break;
        end
      end
      check_eq("init_ready_cycle", 32'(rdy), 32'(16 * 2 * DIV0 + 2 + 80 * DIV0 + 1));
    end
    check_eq("init_wrmr_cnt", 32'(wrmr_cnt[0]), 32'd1);
    check_eq("init_mode", 32'(mode_m[0]), 32'h40);
    ref_mem[0][16'h0010] = 8'h5A;
    ref_mem[0][16'h0011] = 8'hA5;
    @(negedge clk);
    mem_req[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("init_sram", 32'(sram[0][16'h0010]), 32'h5A);
`else
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("idle_busy0", 32'(busy[0]), 32'd0);
      check_eq("idle_busy1", 32'(busy[1]), 32'd0);
    end
`endif

    // Directed write/read/write on the CLK_DIV=1 instance.
    do_access(0, 1'b1, 16'h00A0, 16'h1234, 0);
    do_access(0, 1'b0, 16'h00A0, 16'h0000, 0);
    check_eq("read_a0", 32'(mem_rdata[0]), 32'h1234);
    do_access(0, 1'b1, 16'h0100, 16'h5555, 0);
    check_eq("rdata_hold", 32'(mem_rdata[0]), 32'h1234);
    check_eq("phase_div1", 32'(phase_err[0]), 32'd0);

    // CLK_DIV=3 read with mem_req held 10 cycles after ready.
    falls0 = cs_falls[1];
    do_access(1, 1'b0, 16'(($urandom)), 16'h0000, 10);
    check_eq("no_retrigger", 32'(cs_falls[1] - falls0), 32'd1);

    // Reset asserted at cycle 30 of a write.
    while (busy[0] !== 1'b0) @(negedge clk);
    mem_write[0] = 1'b1; mem_read[0] = 1'b0;
    mem_addr[0] = 16'h0200; mem_wdata[0] = 16'h7777; mem_req[0] = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("mid_cs_low", 32'(spi_cs_n[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs_n", 32'(spi_cs_n[0]), 32'd1);
    check_eq("mid_rst_sck", 32'(spi_sck[0]), 32'd0);
    check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
    mem_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata[0] = 16'h0000;
    exp_rdata[1] = 16'h0000;
    check_eq("mid_rst_rdata0", 32'(mem_rdata[0]), 32'd0);
    check_eq("mid_rst_rdata1", 32'(mem_rdata[1]), 32'd0);
    check_eq("aborted_write", 32'(sram[0][16'h0200]), 32'(ref_mem[0][16'h0200]));
    repeat (3) @(negedge clk);

    // Wrap write across 0xFFFF, then read it back.
    do_access(0, 1'b1, 16'hFFFF, 16'hBEEF, 0);
    check_eq("wrap_ffff", 32'(sram[0][16'hFFFF]), 32'hEF);
    check_eq("wrap_0000", 32'(sram[0][16'h0000]), 32'hBE);
    do_access(0, 1'b0, 16'hFFFF, 16'h0000, 0);
    check_eq("wrap_read", 32'(mem_rdata[0]), 32'hBEEF);

    // Randomized accesses on both instances.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 12; i++) begin
        wr    = 1'($urandom_range(0, 1));
        addr  = (i == 5) ? 16'hFFFF : 16'($urandom);
        wdata = 16'($urandom);
        if (i == 6) addr = 16'hFFFF;
        do_access(g, wr, addr, wdata, int'($urandom_range(0, 3)));
      end
    end
    check_eq("phase_div3", 32'(phase_err[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
